// File: rtl/multi_cycle_memory.sv
// multi_cycle_memory: fixed-latency word memory answering held read/write requests with a one-cycle o_ready pulse
//   clk            : clock, all state changes on the rising edge
//   reset          : synchronous active-high reset (memory contents are kept)
//   i_read/i_write : request strobes, held high until o_ready
//   i_address      : word address, wraps modulo MEM_WORDS
//   i_data         : write data
//   o_data         : registered read data, valid while o_ready
//   o_ready        : one-cycle completion pulse
//   o_protocol_err : sticky protocol-violation flag (only with MEM_PROTOCOL_CHECK_EN defined)
// Optional feature macro: MEM_PROTOCOL_CHECK_EN
module multi_cycle_memory #(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [15:0] i_address,
    input  logic [15:0] i_data,
    output logic [15:0] o_data,
    output logic        o_ready,
    output logic        o_protocol_err
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [15:0] addr_q, data_q;
    logic        wr_q;
    logic [15:0] mem [MEM_WORDS];
    logic        both, mis, req_ok, hold, enter_done;
    logic [15:0] acc_addr, acc_data;
    logic        acc_wr;
    logic [AW-1:0] idx;

`ifdef MEM_PROTOCOL_CHECK_EN
    logic err_q;
    assign both = i_read & i_write;
    assign mis  = (state == BUSY) && (i_address != addr_q);
    assign o_protocol_err = err_q;
    always_ff @(posedge clk)
        if (reset)
            err_q <= 1'b0;
        else if ((state == IDLE && both) || mis)
            err_q <= 1'b1;
`else
    logic unused_mis;
    assign both = 1'b0;
    assign mis  = 1'b0;
    assign unused_mis = ^{mis, addr_q};
    assign o_protocol_err = 1'b0;
`endif

    assign req_ok     = (i_read | i_write) & ~both;
    assign hold       = wr_q ? i_write : i_read;
    assign o_ready    = (state == DONE);
    assign enter_done = (state_nx == DONE);
    // With LATENCY=1 DONE is entered straight from IDLE, before anything is latched.
    assign acc_addr   = (state == IDLE) ? i_address : addr_q;
    assign acc_data   = (state == IDLE) ? i_data    : data_q;
    assign acc_wr     = (state == IDLE) ? i_write   : wr_q;
    assign idx        = acc_addr[AW-1:0];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (req_ok) begin
                state_nx = (LATENCY == 1) ? DONE : BUSY;
                cnt_nx   = 4'(LATENCY - 1);
            end
            BUSY: begin
                // An abort takes priority over finishing the countdown.
                state_nx = !hold ? IDLE : (cnt == 4'd1) ? DONE : BUSY;
                cnt_nx   = (!hold || cnt == 4'd1) ? 4'd0 : cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            o_data <= 16'h0000;
            addr_q <= 16'h0000;
            data_q <= 16'h0000;
            wr_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req_ok) begin
                addr_q <= i_address;
                data_q <= i_data;
                wr_q   <= i_write;
            end
            if (enter_done && !acc_wr)
                o_data <= mem[idx];
        end
    end

    always_ff @(posedge clk)
        if (!reset && enter_done && acc_wr)
            mem[idx] <= acc_data;
endmodule

// File: tb/tb_multi_cycle_memory.sv
// tb_multi_cycle_memory: directed checks of latency, wrap-around, abort, reset and protocol handling
module tb_multi_cycle_memory;
    logic        clk = 1'b0, reset = 1'b1, i_read = 1'b0, i_write = 1'b0;
    logic [15:0] i_address = 16'h0, i_data = 16'h0;
    logic [15:0] o_data, o_data1;
    logic        o_ready, o_ready1, o_protocol_err, o_protocol_err1;
    logic [15:0] mask, data;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    multi_cycle_memory #(.LATENCY(4), .MEM_WORDS(256)) u_dut (
        .clk(clk), .reset(reset), .i_read(i_read), .i_write(i_write),
        .i_address(i_address), .i_data(i_data),
        .o_data(o_data), .o_ready(o_ready), .o_protocol_err(o_protocol_err)
    );

    multi_cycle_memory #(.LATENCY(1), .MEM_WORDS(256)) u_dut1 (
        .clk(clk), .reset(reset), .i_read(i_read), .i_write(i_write),
        .i_address(i_address), .i_data(i_data),
        .o_data(o_data1), .o_ready(o_ready1), .o_protocol_err(o_protocol_err1)
    );

    task check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts in cycle 0 (just after an edge); request held for cycles 0..hold-1,
    // o_ready sampled per cycle into m, o_data captured while o_ready.
    task run(input bit sel, input logic rd, input logic wr, input logic [15:0] a,
             input logic [15:0] d, input int hold, input int obs,
             output logic [15:0] m, output logic [15:0] q);
        m = 16'h0;
        q = 16'h0;
        i_read = rd;
        i_write = wr;
        i_address = a;
        i_data = d;
        for (int c = 0; c < obs; c++) begin
            if (c == hold) begin
                i_read = 1'b0;
                i_write = 1'b0;
            end
            @(negedge clk);
            if (sel ? o_ready1 : o_ready) begin
                m[c] = 1'b1;
                q = sel ? o_data1 : o_data;
            end
            @(posedge clk);
            #1;
        end
        i_read = 1'b0;
        i_write = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {15'h0, o_ready}, 16'h0);
        check("rst_data", o_data, 16'h0000);
        check("rst_err", {15'h0, o_protocol_err}, 16'h0);
        @(posedge clk);
        #1;

        run(0, 0, 1, 16'h0010, 16'hBEEF, 4, 6, mask, data);
        check("wr_beef_ready", mask, 16'h0010);
        run(0, 1, 0, 16'h0010, 16'h0000, 4, 6, mask, data);
        check("rd_beef_ready", mask, 16'h0010);
        check("rd_beef_data", data, 16'hBEEF);

        run(0, 1, 0, 16'h0010, 16'h0000, 10, 11, mask, data);
        check("b2b_ready", mask, 16'h0210);

        run(0, 0, 1, 16'h0010, 16'h1234, 4, 6, mask, data);
        run(0, 1, 0, 16'h0110, 16'h0000, 4, 6, mask, data);
        check("wrap_ready", mask, 16'h0010);
        check("wrap_data", data, 16'h1234);

        run(0, 0, 1, 16'h0005, 16'h7777, 4, 6, mask, data);
        run(0, 0, 1, 16'h0005, 16'hAAAA, 2, 6, mask, data);
        check("abort_ready", mask, 16'h0000);
        run(0, 1, 0, 16'h0005, 16'h0000, 4, 6, mask, data);
        check("abort_data", data, 16'h7777);

        i_write = 1'b1;
        i_address = 16'h0005;
        i_data = 16'h5555;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        i_write = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", {15'h0, o_ready}, 16'h0);
        check("midrst_data", o_data, 16'h0000);
        check("midrst_err", {15'h0, o_protocol_err}, 16'h0);
        @(posedge clk);
        #1;
        run(0, 1, 0, 16'h0005, 16'h0000, 4, 6, mask, data);
        check("midrst_rd_ready", mask, 16'h0010);
        check("midrst_rd_data", data, 16'h7777);

        run(0, 1, 1, 16'h0020, 16'hC0DE, 4, 6, mask, data);
`ifdef MEM_PROTOCOL_CHECK_EN
        check("both_ready", mask, 16'h0000);
        check("both_err", {15'h0, o_protocol_err}, 16'h1);
        run(0, 1, 0, 16'h0010, 16'h0000, 4, 6, mask, data);
        check("both_err_sticky", {15'h0, o_protocol_err}, 16'h1);
`else
        check("both_ready", mask, 16'h0010);
        check("both_err", {15'h0, o_protocol_err}, 16'h0);
        run(0, 1, 0, 16'h0020, 16'h0000, 4, 6, mask, data);
        check("both_wr_data", data, 16'hC0DE);
`endif

        run(1, 0, 1, 16'h0003, 16'h0042, 1, 3, mask, data);
        check("lat1_wr_ready", mask, 16'h0002);
        run(1, 1, 0, 16'h0003, 16'h0000, 3, 5, mask, data);
        check("lat1_rd_ready", mask, 16'h000A);
        check("lat1_rd_data", data, 16'h0042);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
